mmio_responder: RTL
===================

Name: mmio_responder

Overview:
Memory-mapped I/O responder on the processor's data-memory bus. It sits between the processor's dmem port and the dmem syncram, and decodes a small I/O window at the top of the 12-bit address space. Inside that window it serves debounced push-button state, sticky press events, an LED/output register and a free-running cycle counter. All other addresses pass through to dmem unchanged. It complements the debug register-readout path by letting software read the buttons directly.

Parameters:
IO_BASE, 8'hFF, address[11:4] value that selects the I/O window (0xFF0-0xFFF)
N_BTN, 4, number of push-button inputs
DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required before a debounced level changes (minimum 2)

Ports:
clock  in  1  block clock; instantiated with the same inverted clock as dmem (~clock)
reset  in  1  synchronous, active-high reset
address  in  12  processor dmem address
data  in  32  processor write data
wren  in  1  processor write enable
q  out  32  read data returned to processor
dmem_wren  out  1  write enable forwarded to dmem syncram
dmem_q  in  32  read data from dmem syncram
btn  in  N_BTN  raw asynchronous push-button levels, active-high
led  out  32  LED/output register contents
btn_irq  out  1  high while any BTN_EVT bit is set

Behaviour:
- One clock; reset synchronous, active-high; every flop resets on the rising clock edge with reset=1.
- hit = (address[11:4] == IO_BASE). dmem_wren = wren & ~hit (combinational); the dmem address and data are wired directly to dmem, outside this block.
- Register map (word offsets in address[3:0]):
  - 0x0 BTN_RAW, read-only: debounced levels in [N_BTN-1:0].
  - 0x1 BTN_EVT, write-1-to-clear: sticky debounced rising edges.
  - 0x2 LED, read/write.
  - 0x3 CYCLE, read-only counter; any write clears it to 0.
  - 0x4-0xF are reserved: reads return 0, writes are ignored.
- Read latency is 1 clock, matching dmem. On each edge, register hit_q <= hit and io_rdata_q <= the selected register value. Then q = hit_q ? io_rdata_q : dmem_q (combinational mux).
- Writes take effect on the edge where hit & wren; the new value is readable on the following access.
- Synchronizer: 2-flop synchronizer per button; reset value 0.
- Debouncer, per button:
  - Holds a stable level and a counter.
  - If sync != stable, the counter increments. On the edge where the counter reaches DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0.
  - If sync == stable, counter <= 0.
  - The counter width is $clog2(DEBOUNCE_CYCLES)+1 and never wraps.
- Events: BTN_EVT[i] sets on the cycle where stable[i] goes 0->1.
  - If a set and a W1C clear hit the same bit on the same edge, the set wins.
  - Writing 0 bits leaves those bits unchanged.
- CYCLE is 32-bit, increments every clock and wraps 0xFFFFFFFF -> 0.
  - A write to CYCLE forces 0 on that edge; the counter reads 1 one clock later.
- btn_irq = |BTN_EVT, registered.
- Reset values: led=0, BTN_EVT=0, stable=0, counters=0, CYCLE=0, hit_q=0, io_rdata_q=0, btn_irq=0. q therefore equals dmem_q immediately after reset.
- Reset asserted mid-debounce discards the partial count. A press held across reset must be re-debounced in full after reset deasserts.
- Back-to-back accesses (read, write, read at the same or different addresses on consecutive cycles) are fully supported with no stalls. The block has no handshake, because the processor assumes fixed latency.

Decomposition:
- Shared package mmio_pkg holds:
  - IO_BASE;
  - register offsets: OFF_BTN_RAW=4'h0, OFF_BTN_EVT=4'h1, OFF_LED=4'h2, OFF_CYCLE=4'h3;
  - DATA_W=32 and ADDR_W=12.
- One sub-module, btn_debounce (single button: synchronizer + debounce counter + rising-edge pulse). It is instantiated N_BTN times by a generate loop.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset, then read 0x005 with dmem_q=0xDEADBEEF -> q=0xDEADBEEF one clock later; dmem_wren follows wren for address 0x005.
- Write 0xA5A5_0001 to 0xFF2, then read 0xFF2 -> led=0xA5A50001 and q=0xA5A50001; dmem_wren stays 0 during the write.
- Raise btn[2], hold it 10 cycles -> BTN_RAW=0x4 after 2+4 cycles, BTN_EVT=0x4, btn_irq=1. A glitch on btn[1] lasting 2 cycles leaves BTN_RAW[1]=0.
- With BTN_EVT=0x4, write 0x4 to 0xFF1 on the same edge as a new rising edge on btn[0] -> BTN_EVT=0x1 and btn_irq stays 1. Then write 0x1 -> BTN_EVT=0 and btn_irq=0.
- Write any value to 0xFF3, then read it 5 cycles later -> q=5.
- Mid-debounce of btn[3] (count 2), assert reset for 1 cycle -> every output is 0, and BTN_RAW[3] rises only 6 cycles after reset deasserts. Reads of 0xFF8 return 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the dmem-side MMIO responder:
// window base, register offsets and bus widths.
package mmio_pkg;
    localparam int         DATA_W      = 32;
    localparam int         ADDR_W      = 12;
    localparam logic [7:0] IO_BASE     = 8'hFF;
    localparam logic [3:0] OFF_BTN_RAW = 4'h0;
    localparam logic [3:0] OFF_BTN_EVT = 4'h1;
    localparam logic [3:0] OFF_LED     = 4'h2;
    localparam logic [3:0] OFF_CYCLE   = 4'h3;
endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stability counter
// and a pulse on the debounced 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_flip;

    assign w_diff = r_s2 != r_stable;
    assign w_flip = w_diff && (r_cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            if (w_flip) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_stable;
    // Fires on the same edge the level flips, so the event bit lines up.
    assign o_rise  = w_flip & r_s2;
endmodule

// File: rtl/mmio_responder.sv
// I/O window at the top of dmem space: buttons, sticky events,
// LED register and a cycle counter; everything else goes to dmem.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [7:0] IO_BASE         = mmio_pkg::IO_BASE,
    parameter int         N_BTN           = 4,
    parameter int         DEBOUNCE_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    output logic              dmem_wren,
    input  logic [DATA_W-1:0] dmem_q,
    input  logic [N_BTN-1:0]  btn,
    output logic [DATA_W-1:0] led,
    output logic              btn_irq
);
    logic              w_hit;
    logic              w_wr;
    logic [3:0]        w_off;
    logic [N_BTN-1:0]  w_level;
    logic [N_BTN-1:0]  w_rise;
    logic [N_BTN-1:0]  w_clr;
    logic [N_BTN-1:0]  w_evt_nxt;
    logic [DATA_W-1:0] w_rdata;

    logic              r_hit_q;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_led;
    logic [DATA_W-1:0] r_cyc;
    logic [N_BTN-1:0]  r_evt;
    logic              r_irq;

    assign w_hit     = address[ADDR_W-1:4] == IO_BASE;
    assign w_off     = address[3:0];
    assign w_wr      = w_hit & wren;
    assign dmem_wren = wren & ~w_hit;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock  (clock),
            .reset  (reset),
            .i_btn  (btn[g]),
            .o_level(w_level[g]),
            .o_rise (w_rise[g])
        );
    end

    // A new edge outranks a same-cycle W1C of that bit.
    assign w_clr = (w_wr && w_off == OFF_BTN_EVT) ? data[N_BTN-1:0] : '0;
    assign w_evt_nxt = (r_evt & ~w_clr) | w_rise;

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_off == OFF_BTN_RAW: w_rdata[N_BTN-1:0] = w_level;
            w_off == OFF_BTN_EVT: w_rdata[N_BTN-1:0] = r_evt;
            w_off == OFF_LED:     w_rdata = r_led;
            w_off == OFF_CYCLE:   w_rdata = r_cyc;
            default:              w_rdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_q <= 1'b0;
            r_rdata <= '0;
            r_led   <= '0;
            r_cyc   <= '0;
            r_evt   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_hit_q <= w_hit;
            r_rdata <= w_rdata;
            if (w_wr && w_off == OFF_LED) begin
                r_led <= data;
            end
            if (w_wr && w_off == OFF_CYCLE) begin
                r_cyc <= '0;
            end else begin
                r_cyc <= r_cyc + 1'b1;
            end
            r_evt <= w_evt_nxt;
            r_irq <= |w_evt_nxt;
        end
    end

    assign q       = r_hit_q ? r_rdata : dmem_q;
    assign led     = r_led;
    assign btn_irq = r_irq;
endmodule
